write_fsm: RTL and testbench
============================

// Module: write_fsm
// PURPOSE
//  Write-side sequencer for the NMC array; counterpart of the read sequencer.
//  Accepts 9-bit words from TOP one at a time, drives the write driver (WD) and decoder address,
//  then steps the address (+1 word mode, +128 column mode).
//  Sits between TOP and the WD/decoder; optional SA read-back verify with retry.
// PARAMETERS
//  AW          21  address width (decoder / init_addr / out_addr)
//  DW          9   data word width
//  PULSE_MAX   64  max cycles WD_en held waiting for write_finish before timeout (>=2)
//  MAX_RETRY   3   re-program attempts after verify mismatch (WRITE_VERIFY_EN only)
// PORTS
//  sys_clk      in   1   single clock, all logic rising-edge
//  rst          in   1   synchronous, active-high reset
//  sys_en       in   1   block enable; low forces IDLE
//  mode         in   1   0: word mode (+1, full data); 1: column mode (+128, data[0] forced 0)
//  wren         in   1   TOP write strobe, qualified by request
//  init_addr    in   AW  start address, sampled while in IDLE
//  data_in      in   DW  write data, captured on accepted wren
//  write_finish in   1   WD done pulse/level
//  read_finish  in   1   SA done (verify only)
//  SA_out       in   DW  SA read data (verify only)
//  request      out  1   ready for next word (high only in WAIT)
//  WD_en        out  1   write driver enable
//  WD_data      out  DW  data to write driver
//  address      out  AW  decoder address
//  out_addr     out  AW  address of word currently being written (to TOP)
//  SA_en        out  1   sense amp enable (verify only)
//  wr_err       out  1   sticky: timeout or verify failure since leaving IDLE
// BEHAVIOUR
//  - All outputs registered. On rst=1 (any state, mid-write included): state=IDLE, every output 0,
//    pulse counter and retry counter 0. WD_en must read 0 in the cycle after rst is sampled.
//  - IDLE: address<=init_addr each cycle, wr_err<=0, request=0. sys_en=1 -> WAIT.
//  - WAIT: request=1. wren=1 -> capture WD_data<=mode?{data_in[8:1],1'b0}:data_in,
//    out_addr<=address, request<=0, -> PROG. wren=0 -> stay.
//  - PROG: WD_en=1 (first high cycle = cycle after accepted wren); pulse counter increments.
//    write_finish=1 -> WD_en<=0, -> VERIFY (macro) else ADDR. Counter reaches PULSE_MAX-1
//    without finish -> WD_en<=0, wr_err<=1, -> ADDR (word skipped). Counter cleared on PROG entry.
//  - VERIFY: SA_en=1 until read_finish=1; then SA_en<=0, -> CMP.
//  - CMP: compare SA_out (masked as WD_data in column mode) to WD_data. Match -> ADDR.
//    Mismatch & retry<MAX_RETRY -> retry++, -> PROG. Mismatch & retry==MAX_RETRY -> wr_err<=1, -> ADDR.
//    Retry counter cleared on WAIT->PROG.
//  - ADDR: address<=address+(mode?128:1), modulo 2^AW (wraps silently, no flag). -> DELAY.
//  - DELAY: one idle cycle, all enables 0. -> WAIT (request=1 the following cycle).
//  - mode sampled in ADDR/WAIT capture; changing it mid-word affects only the next step/capture.
//  - sys_en=0 in any non-IDLE state: next cycle IDLE, WD_en/SA_en/request forced 0; the
//    in-flight word is abandoned, address reloads from init_addr.
//  - write_finish or wren outside PROG/WAIT respectively: ignored.
//  - Throughput (no verify, finish on first PROG cycle): accepted wren every 4 cycles.
// CONFIGURATION
//  WRITE_VERIFY_EN defined: VERIFY/CMP states, retry counter and SA handshake present.
//  Not defined: PROG -> ADDR directly; SA_en tied 0; read_finish/SA_out ignored;
//  wr_err set only by timeout. Ports exist in both builds.
// TESTING
//  T1 reset: assert rst in PROG with WD_en=1 -> next cycle all outputs 0, state IDLE.
//  T2 word mode: init_addr=0x00010, mode=0, write 0x1A5,0x0FF -> WD_data 0x1A5 @out_addr 0x00010,
//     0x0FF @0x00011, address 0x00012 after 2nd word.
//  T3 column mode/wrap: init_addr=0x1FFFC0, mode=1, data 0x1FF -> WD_data 0x1FE, address 0x000040.
//  T4 timeout: write_finish held 0 -> WD_en high exactly PULSE_MAX cycles, wr_err=1, address steps.
//  T5 verify (macro): SA_out mismatches 3x then matches -> 4 PROG pulses, wr_err=0;
//     mismatch 4x -> wr_err=1 after 4th CMP.
//  T6 abort: drop sys_en during PROG -> WD_en 0 next cycle, IDLE, address=init_addr.

Source files
------------

// File: rtl/write_fsm_if.sv
// Handshake/data bundle between TOP, the write sequencer, the write driver and the sense amp.
// slave modport is the sequencer's view; master is the TOP/array side.
interface write_fsm_if #(
    parameter int AW = 21,
    parameter int DW = 9
);
    logic          sys_en;
    logic          mode;
    logic          wren;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] data_in;
    logic          write_finish;
    logic          read_finish;
    logic [DW-1:0] SA_out;
    logic          request;
    logic          WD_en;
    logic [DW-1:0] WD_data;
    logic [AW-1:0] address;
    logic [AW-1:0] out_addr;
    logic          SA_en;
    logic          wr_err;

    modport slave (
        input  sys_en, mode, wren, init_addr, data_in, write_finish, read_finish, SA_out,
        output request, WD_en, WD_data, address, out_addr, SA_en, wr_err
    );

    modport master (
        output sys_en, mode, wren, init_addr, data_in, write_finish, read_finish, SA_out,
        input  request, WD_en, WD_data, address, out_addr, SA_en, wr_err
    );
endinterface

// File: rtl/write_fsm.sv
// Write-side sequencer for the NMC array: takes words from TOP, pulses the write driver, steps the address.
// Optional SA read-back verify with retry is enabled by defining WRITE_VERIFY_EN.
module write_fsm #(
    parameter int AW        = 21,
    parameter int DW        = 9,
    parameter int PULSE_MAX = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    write_fsm_if.slave bus
);
    localparam int CW = (PULSE_MAX > 2) ? $clog2(PULSE_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT, PROG, VERIFY, CMP, ADDR, DELAY
    } state_t;

    state_t        state_q;
    logic          request_q;
    logic          wd_en_q;
    logic [DW-1:0] wd_data_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] out_addr_q;
    logic          wr_err_q;
    logic [CW-1:0] pulse_q;
    logic [DW-1:0] wd_data_d;
    logic [AW-1:0] addr_d;

    // Column mode stores only the upper bits; bit 0 of every column word is forced low.
    assign wd_data_d = bus.mode ? {bus.data_in[DW-1:1], 1'b0} : bus.data_in;
    assign addr_d    = addr_q + (bus.mode ? AW'(128) : AW'(1));

`ifdef WRITE_VERIFY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic          sa_en_q;
    logic          col_q;
    logic [RW-1:0] retry_q;
    logic [DW-1:0] sa_cmp;

    assign sa_cmp    = col_q ? {bus.SA_out[DW-1:1], 1'b0} : bus.SA_out;
    assign bus.SA_en = sa_en_q;
`else
    logic unused_verify;
    assign unused_verify = ^{bus.read_finish, bus.SA_out};
    assign bus.SA_en     = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            request_q  <= 1'b0;
            wd_en_q    <= 1'b0;
            wd_data_q  <= '0;
            addr_q     <= '0;
            out_addr_q <= '0;
            wr_err_q   <= 1'b0;
            pulse_q    <= '0;
`ifdef WRITE_VERIFY_EN
            sa_en_q    <= 1'b0;
            col_q      <= 1'b0;
            retry_q    <= '0;
`endif
        end else if (!bus.sys_en && state_q != IDLE) begin
            // Abort: the in-flight word is dropped, address reloads.
            state_q   <= IDLE;
            request_q <= 1'b0;
            wd_en_q   <= 1'b0;
            addr_q    <= bus.init_addr;
`ifdef WRITE_VERIFY_EN
            sa_en_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q    <= bus.init_addr;
                    wr_err_q  <= 1'b0;
                    request_q <= 1'b0;
                    wd_en_q   <= 1'b0;
                    if (bus.sys_en) begin
                        state_q   <= WAIT;
                        request_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.wren) begin
                        wd_data_q  <= wd_data_d;
                        out_addr_q <= addr_q;
                        request_q  <= 1'b0;
                        wd_en_q    <= 1'b1;
                        pulse_q    <= '0;
                        state_q    <= PROG;
`ifdef WRITE_VERIFY_EN
                        col_q      <= bus.mode;
                        retry_q    <= '0;
`endif
                    end
                end
                PROG: begin
                    if (bus.write_finish) begin
                        wd_en_q <= 1'b0;
`ifdef WRITE_VERIFY_EN
                        sa_en_q <= 1'b1;
                        state_q <= VERIFY;
`else
                        state_q <= ADDR;
`endif
                    end else if (pulse_q == CW'(PULSE_MAX - 1)) begin
                        wd_en_q  <= 1'b0;
                        wr_err_q <= 1'b1;
                        state_q  <= ADDR;
                    end else begin
                        pulse_q <= pulse_q + 1'b1;
                    end
                end
`ifdef WRITE_VERIFY_EN
                VERIFY: begin
                    if (bus.read_finish) begin
                        sa_en_q <= 1'b0;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    if (sa_cmp == wd_data_q) begin
                        state_q <= ADDR;
                    end else if (retry_q != RW'(MAX_RETRY)) begin
                        retry_q <= retry_q + 1'b1;
                        pulse_q <= '0;
                        wd_en_q <= 1'b1;
                        state_q <= PROG;
                    end else begin
                        wr_err_q <= 1'b1;
                        state_q  <= ADDR;
                    end
                end
`endif
                ADDR: begin
                    addr_q  <= addr_d;
                    state_q <= DELAY;
                end
                DELAY: begin
                    request_q <= 1'b1;
                    state_q   <= WAIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.request  = request_q;
    assign bus.WD_en    = wd_en_q;
    assign bus.WD_data  = wd_data_q;
    assign bus.address  = addr_q;
    assign bus.out_addr = out_addr_q;
    assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_write_fsm.sv
// Directed bench for write_fsm: reset, word/column stepping, timeout, throughput, abort, optional verify.
module tb_write_fsm;
    localparam int AW = 21;
    localparam int DW = 9;
    localparam int PM = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    write_fsm_if #(.AW(AW), .DW(DW)) bus ();

    write_fsm #(.AW(AW), .DW(DW), .PULSE_MAX(PM), .MAX_RETRY(3)) dut (
        .sys_clk_i (clk),
        .rst_i     (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the block from IDLE into WAIT with the given start address.
    task automatic start(input logic [AW-1:0] a, input logic m);
        bus.sys_en    = 1'b0;
        tick();
        bus.init_addr = a;
        bus.mode      = m;
        bus.sys_en    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        n_run++;
        if ({bus.request, bus.WD_en, bus.SA_en, bus.wr_err} !== 4'b0 || bus.address !== '0 ||
            bus.WD_data !== '0 || bus.out_addr !== '0) begin
            n_fail++; $display("FAIL reset_state: req=%b wd=%b addr=%h", bus.request, bus.WD_en, bus.address);
        end
        rst = 1'b0;
        start(21'h00123, 1'b0);
        bus.data_in = 9'h055; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        n_run++;
        if (bus.WD_en !== 1'b1) begin n_fail++; $display("FAIL reset_pre_prog: WD_en=%b want 1", bus.WD_en); end
        rst = 1'b1;
        tick();
        n_run++;
        if ({bus.request, bus.WD_en, bus.SA_en, bus.wr_err} !== 4'b0 || bus.address !== '0 ||
            bus.WD_data !== '0 || bus.out_addr !== '0) begin
            n_fail++; $display("FAIL reset_mid_prog: wd=%b data=%h addr=%h want zeros", bus.WD_en, bus.WD_data, bus.address);
        end
        rst = 1'b0;
        bus.sys_en = 1'b0;
        tick();
    endtask

    task automatic test_word_mode();
        start(21'h00010, 1'b0);
        n_run++;
        if (bus.request !== 1'b1 || bus.address !== 21'h00010) begin
            n_fail++; $display("FAIL word_wait: req=%b addr=%h want 1/00010", bus.request, bus.address);
        end
        bus.data_in = 9'h1A5; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0; bus.write_finish = 1'b1;
        n_run++;
        if (bus.WD_en !== 1'b1 || bus.WD_data !== 9'h1A5 || bus.out_addr !== 21'h00010 || bus.request !== 1'b0) begin
            n_fail++; $display("FAIL word_first: wd=%b data=%h oa=%h want 1/1a5/00010", bus.WD_en, bus.WD_data, bus.out_addr);
        end
        tick();
        bus.write_finish = 1'b0;
        n_run++;
        if (bus.WD_en !== 1'b0) begin n_fail++; $display("FAIL word_wd_drop: WD_en=%b want 0", bus.WD_en); end
        tick(); tick();
        n_run++;
        if (bus.request !== 1'b1 || bus.address !== 21'h00011) begin
            n_fail++; $display("FAIL word_step1: req=%b addr=%h want 1/00011", bus.request, bus.address);
        end
        bus.data_in = 9'h0FF; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0; bus.write_finish = 1'b1;
        n_run++;
        if (bus.WD_data !== 9'h0FF || bus.out_addr !== 21'h00011) begin
            n_fail++; $display("FAIL word_second: data=%h oa=%h want 0ff/00011", bus.WD_data, bus.out_addr);
        end
        tick();
        bus.write_finish = 1'b0;
        tick();
        n_run++;
        if (bus.address !== 21'h00012 || bus.wr_err !== 1'b0) begin
            n_fail++; $display("FAIL word_step2: addr=%h err=%b want 00012/0", bus.address, bus.wr_err);
        end
        tick();
    endtask

    task automatic test_column_wrap();
        start(21'h1FFFC0, 1'b1);
        bus.data_in = 9'h1FF; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0; bus.write_finish = 1'b1;
        n_run++;
        if (bus.WD_data !== 9'h1FE || bus.out_addr !== 21'h1FFFC0) begin
            n_fail++; $display("FAIL col_data: data=%h oa=%h want 1fe/1fffc0", bus.WD_data, bus.out_addr);
        end
        tick();
        bus.write_finish = 1'b0;
        tick(); tick();
        n_run++;
        if (bus.address !== 21'h000040 || bus.request !== 1'b1) begin
            n_fail++; $display("FAIL col_wrap: addr=%h req=%b want 000040/1", bus.address, bus.request);
        end
    endtask

    // Continues from WAIT at 0x000040 left by the column test.
    task automatic test_timeout();
        int hi = 0;
        bus.mode = 1'b0;
        bus.data_in = 9'h003; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        for (int i = 0; i < 4 * PM && bus.WD_en; i++) begin
            hi++;
            tick();
        end
        n_run++;
        if (hi !== PM) begin n_fail++; $display("FAIL timeout_len: WD_en high %0d cycles want %0d", hi, PM); end
        n_run++;
        if (bus.wr_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: wr_err=%b want 1", bus.wr_err); end
        tick(); tick();
        n_run++;
        if (bus.address !== 21'h000041 || bus.request !== 1'b1 || bus.wr_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_step: addr=%h req=%b err=%b want 000041/1/1", bus.address, bus.request, bus.wr_err);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        start(21'h00200, 1'b0);
        bus.wren = 1'b1; bus.write_finish = 1'b1; bus.data_in = 9'h0AA;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.WD_en) pulses++;
        end
        bus.wren = 1'b0; bus.write_finish = 1'b0;
        n_run++;
        if (pulses !== 4 || bus.address !== 21'h00204) begin
            n_fail++; $display("FAIL back_to_back: pulses=%0d addr=%h want 4/00204", pulses, bus.address);
        end
    endtask

    task automatic test_abort();
        start(21'h00300, 1'b0);
        bus.data_in = 9'h011; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0;
        bus.init_addr = 21'h00777;
        bus.sys_en = 1'b0;
        tick();
        n_run++;
        if (bus.WD_en !== 1'b0 || bus.request !== 1'b0 || bus.address !== 21'h00777) begin
            n_fail++; $display("FAIL abort: wd=%b req=%b addr=%h want 0/0/00777", bus.WD_en, bus.request, bus.address);
        end
        tick();
        n_run++;
        if (bus.request !== 1'b0 || bus.wr_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: req=%b err=%b want 0/0", bus.request, bus.wr_err);
        end
    endtask

`ifdef WRITE_VERIFY_EN
    task automatic run_verify(input int good_after, output int pulses);
        pulses = 0;
        bus.data_in = 9'h15A; bus.wren = 1'b1;
        tick();
        bus.wren = 1'b0; bus.write_finish = 1'b1; bus.read_finish = 1'b1;
        for (int i = 0; i < 60 && !bus.request; i++) begin
            if (bus.WD_en) pulses++;
            bus.SA_out = (pulses >= good_after) ? 9'h15A : 9'h000;
            tick();
        end
        bus.write_finish = 1'b0; bus.read_finish = 1'b0;
    endtask

    task automatic test_verify();
        int p;
        start(21'h00400, 1'b0);
        run_verify(4, p);
        n_run++;
        if (p !== 4 || bus.wr_err !== 1'b0 || bus.address !== 21'h00401) begin
            n_fail++; $display("FAIL verify_retry: pulses=%0d err=%b addr=%h want 4/0/00401", p, bus.wr_err, bus.address);
        end
        run_verify(99, p);
        n_run++;
        if (p !== 4 || bus.wr_err !== 1'b1 || bus.address !== 21'h00402) begin
            n_fail++; $display("FAIL verify_give_up: pulses=%0d err=%b addr=%h want 4/1/00402", p, bus.wr_err, bus.address);
        end
    endtask
`endif

    initial begin
        bus.sys_en = 1'b0; bus.mode = 1'b0; bus.wren = 1'b0; bus.init_addr = '0;
        bus.data_in = '0; bus.write_finish = 1'b0; bus.read_finish = 1'b0; bus.SA_out = '0;
        tick(); tick();
        test_reset();
        test_word_mode();
        test_column_wrap();
        test_timeout();
        test_back_to_back();
        test_abort();
`ifdef WRITE_VERIFY_EN
        test_verify();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
